// File: rtl/shift_seq_pkg.sv
// shift_pkg: shared types for the shift_seq multi-mode shifter
//   shift_mode_t : command mode codes (5..7 reserved)
//   state_t      : control FSM states
package shift_pkg;
  typedef enum logic [2:0] {SLL, SRL, SRA, ROL, ROR} shift_mode_t;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/shift_seq_if.sv
// shift_seq_if: command/data bundle of the shift_seq unit
//   master drives load/load_data/start/mode/amount/sin, slave drives q/sout/busy/done
interface shift_seq_if #(parameter int WIDTH = 8);
  localparam int AW = $clog2(WIDTH + 1);
  logic load;
  logic [WIDTH-1:0] load_data;
  logic start;
  logic [2:0] mode;
  logic [AW-1:0] amount;
  logic sin;
  logic [WIDTH-1:0] q;
  logic sout;
  logic busy;
  logic done;
  modport master(output load, load_data, start, mode, amount, sin, input q, sout, busy, done);
  modport slave(input load, load_data, start, mode, amount, sin, output q, sout, busy, done);
endinterface

// File: rtl/shift_seq_step.sv
// shift_step: combinational shift of q by n (1..STEP) bits in one mode
//   in  q, n, mode, fill (vacated-bit value for SLL/SRL)
//   out nq (shifted value), sout (last bit out, or wrapped edge bit for rotates)
module shift_step import shift_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int STEP = 1,
  parameter int AW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] q,
  input  logic [AW-1:0]    n,
  input  shift_mode_t      mode,
  input  logic             fill,
  output logic [WIDTH-1:0] nq,
  output logic             sout
);
  logic [WIDTH-1:0] cur;
  logic so;
  // n single-bit shifts; the last bit pushed out is the innermost one, and
  // SRA re-copies the unchanged msb so every vacated bit gets the same fill
  always_comb begin
    cur = q;
    so = 1'b0;
    for (int i = 0; i < STEP; i++)
      if (AW'(i) < n) begin
        so = (mode == SLL) ? cur[WIDTH-1] : cur[0];
        cur = (mode == SLL) ? {cur[WIDTH-2:0], fill} :
              (mode == SRL) ? {fill, cur[WIDTH-1:1]} :
              (mode == SRA) ? {cur[WIDTH-1], cur[WIDTH-1:1]} :
              (mode == ROL) ? {cur[WIDTH-2:0], cur[WIDTH-1]} :
              (mode == ROR) ? {cur[0], cur[WIDTH-1:1]} : cur;
      end
    nq = cur;
    sout = (mode == ROL) ? cur[0] : (mode == ROR) ? cur[WIDTH-1] : so;
  end
endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-mode sequential shifter with load and multi-cycle shift-by-N
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : shift_seq_if slave (load/start command in, q/sout/busy/done out)
module shift_seq import shift_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int STEP = 1
) (
  input logic clk,
  input logic rst,
  shift_seq_if.slave bus
);
  localparam int AW = $clog2(WIDTH + 1);
  state_t state;
  shift_mode_t md;
  logic [AW-1:0] rem, clamp, n;
  logic [WIDTH-1:0] q, nq;
  logic sout, ns, busy, done;
  assign clamp = (bus.amount > AW'(WIDTH)) ? AW'(WIDTH) : bus.amount;
  assign n = (rem < AW'(STEP)) ? rem : AW'(STEP);
  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .AW(AW)) u_step (
    .q(q), .n(n), .mode(md), .fill(bus.sin), .nq(nq), .sout(ns)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      md <= SLL;
      rem <= '0;
      q <= '0;
      sout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (bus.load) q <= bus.load_data;
        else if (bus.start) begin
          md <= shift_mode_t'(bus.mode);
          rem <= clamp;
          // zero distance or reserved code completes without entering RUN
          if (clamp == '0 || bus.mode > 3'd4) done <= 1'b1;
          else begin
            state <= RUN;
            busy <= 1'b1;
          end
        end
      end else begin
        q <= nq;
        sout <= ns;
        rem <= rem - n;
        if (rem == n) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  assign bus.q = q;
  assign bus.sout = sout;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
